mips_mem_arbiter: RTL and testbench

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

---
 rtl/mips_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mips_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port memory between the instruction
// fetch port and the data load/store port. Each transaction runs through
// IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE (one-cycle done pulse).
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to break simultaneous
// requests in favour of the port not granted last. Without it, the data
// port always wins a tie.
module mips_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_q: 0 = fetch granted last, 1 = data granted last
  logic last_q, last_d;
  assign grant_data = d_req & (~if_req | ~last_q);
`else
  assign grant_data = d_req;
`endif

  // Next-state logic: arbitration in IDLE, wait countdown and read capture in ACCESS
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_req | d_req) begin
          state_d = S_ACCESS;
          cnt_d   = WAIT_INIT;
          owner_d = grant_data;
          we_d    = grant_data & d_we;
          addr_d  = grant_data ? d_addr : if_addr;
          wdata_d = grant_data ? d_wdata : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d  = grant_data;
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          // last ACCESS cycle: memory data is valid, capture it for the owner
          if (!owner_q)   if_rdata_d = mem_rdata;
          else if (!we_q) d_rdata_d  = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Last-owner flag starts at fetch so the first tie goes to data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end
`endif

  // Write strobe only in the first ACCESS cycle (counter still at its load value)
  assign mem_we    = (state_q == S_ACCESS) && we_q && (cnt_q == WAIT_INIT);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = (state_q == S_DONE) && !owner_q;
  assign d_done    = (state_q == S_DONE) &&  owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: main instance with WAIT_CYCLES=1 backed by a
// word memory, plus WAIT_CYCLES=0 and 15 instances for latency extremes.
module tb_mips_mem_arbiter;
  localparam int W = 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_done, d_done, mem_we, busy, owner;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req0, d_req0, if_done0, d_done0, mem_we0, busy0, owner0;
  logic [31:0] if_rdata0, d_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        if_req15, d_req15, if_done15, d_done15, mem_we15, busy15, owner15;
  logic [31:0] if_rdata15, d_rdata15, mem_addr15, mem_wdata15, mem_rdata15;

  // Memory backing the main instance; reference copy kept separately
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_if_rd, exp_d_rd;
  logic        last_own;

  function automatic logic [31:0] rdfn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  assign mem_rdata   = mem[mem_addr[7:2]];
  assign mem_rdata0  = rdfn(mem_addr0);
  assign mem_rdata15 = rdfn(mem_addr15);

  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy), .owner(owner));

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .if_req(if_req0), .if_addr(if_addr), .if_done(if_done0),
    .if_rdata(if_rdata0), .d_req(d_req0), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done0), .d_rdata(d_rdata0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_we(mem_we0), .mem_rdata(mem_rdata0), .busy(busy0), .owner(owner0));

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .if_req(if_req15), .if_addr(if_addr), .if_done(if_done15),
    .if_rdata(if_rdata15), .d_req(d_req15), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done15), .d_rdata(d_rdata15), .mem_addr(mem_addr15), .mem_wdata(mem_wdata15),
    .mem_we(mem_we15), .mem_rdata(mem_rdata15), .busy(busy15), .owner(owner15));

  task automatic test_reset();
    @(negedge clk);
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    total++; if (owner !== 1'b0)   begin bad++; $display("FAIL rst_owner got=%0h exp=0", owner); end
    total++; if (mem_we !== 1'b0)  begin bad++; $display("FAIL rst_mem_we got=%0h exp=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%0h exp=0", mem_wdata); end
    total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL rst_if_rdata got=%0h exp=0", if_rdata); end
    total++; if (d_rdata !== 32'h0)  begin bad++; $display("FAIL rst_d_rdata got=%0h exp=0", d_rdata); end
    total++; if ({if_done, d_done, busy0, busy15} !== 4'b0) begin bad++; $display("FAIL rst_done_busy got=%0h exp=0", {if_done, d_done, busy0, busy15}); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic saw_we = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    for (int j = 1; j <= W + 2; j++) begin
      @(negedge clk);
      if (mem_we) saw_we = 1'b1;
      if (j == 1) begin
        total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL fetch_addr got=%0h exp=10", mem_addr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fetch_busy got=%0h exp=1", busy); end
      end
      if (j < W + 2) begin
        total++; if (if_done !== 1'b0) begin bad++; $display("FAIL fetch_early_done cyc=%0d got=%0h exp=0", j, if_done); end
      end
    end
    total++; if (if_done !== 1'b1) begin bad++; $display("FAIL fetch_done got=%0h exp=1", if_done); end
    total++; if (d_done !== 1'b0)  begin bad++; $display("FAIL fetch_d_done got=%0h exp=0", d_done); end
    total++; if (if_rdata !== 32'h8C220004) begin bad++; $display("FAIL fetch_rdata got=%0h exp=8c220004", if_rdata); end
    total++; if (saw_we !== 1'b0) begin bad++; $display("FAIL fetch_mem_we got=%0h exp=0", saw_we); end
    if_req = 1'b0;
    exp_if_rd = 32'h8C220004; last_own = 1'b0;
  endtask

  task automatic test_store();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL store_we1 got=%0h exp=1", mem_we); end
    total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL store_addr got=%0h exp=40", mem_addr); end
    total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_wdata got=%0h exp=deadbeef", mem_wdata); end
    total++; if (owner !== 1'b1) begin bad++; $display("FAIL store_owner got=%0h exp=1", owner); end
    d_req = 1'b0;
    @(negedge clk);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL store_we2 got=%0h exp=0", mem_we); end
    total++; if (d_done !== 1'b0) begin bad++; $display("FAIL store_early_done got=%0h exp=0", d_done); end
    @(negedge clk);
    total++; if (d_done !== 1'b1) begin bad++; $display("FAIL store_done got=%0h exp=1", d_done); end
    total++; if (d_rdata !== exp_d_rd) begin bad++; $display("FAIL store_rdata_hold got=%0h exp=%0h", d_rdata, exp_d_rd); end
    d_we = 1'b0;
    ref_mem[16] = 32'hDEADBEEF; last_own = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rma_busy_pre got=%0h exp=1", busy); end
    rst = 1'b1; d_req = 1'b0;
    #1;
    total++; if ({busy, owner, mem_we, d_done} !== 4'b0) begin bad++; $display("FAIL rma_ctrl got=%0h exp=0", {busy, owner, mem_we, d_done}); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rma_addr got=%0h exp=0", mem_addr); end
    total++; if ({if_rdata, d_rdata} !== 64'h0) begin bad++; $display("FAIL rma_rdata got=%0h exp=0", {if_rdata, d_rdata}); end
    exp_if_rd = '0; exp_d_rd = '0; last_own = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      total++; if ({d_done, busy} !== 2'b0) begin bad++; $display("FAIL rma_quiet cyc=%0d got=%0h exp=0", j, {d_done, busy}); end
    end
    d_req = 1'b1;
    for (int j = 1; j <= W + 2; j++) @(negedge clk);
    total++; if (d_done !== 1'b1) begin bad++; $display("FAIL rma_after_done got=%0h exp=1", d_done); end
    total++; if (d_rdata !== ref_mem[16]) begin bad++; $display("FAIL rma_after_rdata got=%0h exp=%0h", d_rdata, ref_mem[16]); end
    d_req = 1'b0; exp_d_rd = ref_mem[16]; last_own = 1'b1;
  endtask

  task automatic test_back_to_back();
    int last_c = 0, n = 0;
    logic exp_w;
    @(negedge clk);
    rst = 1'b1; #1; rst = 1'b0;
    exp_if_rd = '0; exp_d_rd = '0; last_own = 1'b0;
    @(negedge clk);
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h10; d_addr = 32'h40;
    for (int c = 1; c <= 60 && n < 6; c++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        exp_w = RR ? ~last_own : 1'b1;
        last_own = exp_w;
        total++; if ({if_done, d_done} !== {~exp_w, exp_w}) begin bad++; $display("FAIL b2b_grant n=%0d got=%0b exp=%0b", n, {if_done, d_done}, {~exp_w, exp_w}); end
        total++; if ((c - last_c) !== ((n == 0) ? W + 2 : W + 3)) begin bad++; $display("FAIL b2b_period n=%0d got=%0d exp=%0d", n, c - last_c, (n == 0) ? W + 2 : W + 3); end
        if (exp_w) exp_d_rd = ref_mem[16]; else exp_if_rd = ref_mem[4];
        total++; if ({if_rdata, d_rdata} !== {exp_if_rd, exp_d_rd}) begin bad++; $display("FAIL b2b_rdata n=%0d got=%0h exp=%0h", n, {if_rdata, d_rdata}, {exp_if_rd, exp_d_rd}); end
        last_c = c; n++;
      end
    end
    total++; if (n !== 6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", n); end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_random();
    logic        wd, wwe, drop;
    logic [31:0] waddr, wdat;
    logic [1:0]  r;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_idle it=%0d got=%0h exp=0", it, busy); end
      r = 2'($urandom_range(1, 3));
      if_req = r[0]; d_req = r[1];
      if_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      d_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      wd    = d_req && (!if_req || (RR ? !last_own : 1'b1));
      waddr = wd ? d_addr : if_addr;
      wwe   = wd && d_we;
      wdat  = d_wdata;
      last_own = wd;
      drop  = 1'($urandom_range(0, 1));
      for (int j = 1; j <= W + 2; j++) begin
        @(negedge clk);
        total++; if ({busy, owner} !== {1'b1, wd}) begin bad++; $display("FAIL rnd_busy_owner it=%0d j=%0d got=%0b exp=%0b", it, j, {busy, owner}, {1'b1, wd}); end
        total++; if (mem_addr !== waddr) begin bad++; $display("FAIL rnd_addr it=%0d j=%0d got=%0h exp=%0h", it, j, mem_addr, waddr); end
        total++; if (mem_we !== (j == 1 && wwe)) begin bad++; $display("FAIL rnd_we it=%0d j=%0d got=%0h exp=%0h", it, j, mem_we, (j == 1 && wwe)); end
        total++; if ({if_done, d_done} !== {(j == W + 2) && !wd, (j == W + 2) && wd}) begin bad++; $display("FAIL rnd_done it=%0d j=%0d got=%0b exp=%0b", it, j, {if_done, d_done}, {(j == W + 2) && !wd, (j == W + 2) && wd}); end
        if (j == 1) begin
          if (wwe) begin
            total++; if (mem_wdata !== wdat) begin bad++; $display("FAIL rnd_wdata it=%0d got=%0h exp=%0h", it, mem_wdata, wdat); end
          end
          // requests changing mid-access must be ignored
          if (drop) begin if_req = 1'b0; d_req = 1'b0; end
          else begin
            if_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
            if_addr = $urandom & 32'hFC; d_addr = $urandom & 32'hFC; d_we = ~d_we; d_wdata = $urandom;
          end
        end
        if (j == W + 2) begin
          if (wwe) ref_mem[waddr[7:2]] = wdat;
          else if (wd) exp_d_rd = ref_mem[waddr[7:2]];
          else exp_if_rd = ref_mem[waddr[7:2]];
          total++; if ({if_rdata, d_rdata} !== {exp_if_rd, exp_d_rd}) begin bad++; $display("FAIL rnd_rdata it=%0d got=%0h exp=%0h", it, {if_rdata, d_rdata}, {exp_if_rd, exp_d_rd}); end
          if_req = 1'b0; d_req = 1'b0;
        end
      end
    end
  endtask

  task automatic test_wait0();
    int j = 0;
    @(negedge clk);
    if_req0 = 1'b1; if_addr = 32'h20;
    while (j < 40) begin
      @(negedge clk); j++;
      if (if_done0) break;
      if (j == 1) if_req0 = 1'b0;
    end
    total++; if (j !== 2) begin bad++; $display("FAIL w0_latency got=%0d exp=2", j); end
    total++; if (if_rdata0 !== rdfn(32'h20)) begin bad++; $display("FAIL w0_rdata got=%0h exp=%0h", if_rdata0, rdfn(32'h20)); end
    if_req0 = 1'b0;
    @(negedge clk);
    total++; if ({if_done0, busy0} !== 2'b0) begin bad++; $display("FAIL w0_after got=%0b exp=0", {if_done0, busy0}); end
  endtask

  task automatic test_wait15();
    int j = 0;
    @(negedge clk);
    d_req15 = 1'b1; d_we = 1'b0; d_addr = 32'h84;
    while (j < 40) begin
      @(negedge clk); j++;
      if (d_done15) break;
      if (j == 3) d_req15 = 1'b0;
    end
    total++; if (j !== 17) begin bad++; $display("FAIL w15_latency got=%0d exp=17", j); end
    total++; if (d_rdata15 !== rdfn(32'h84)) begin bad++; $display("FAIL w15_rdata got=%0h exp=%0h", d_rdata15, rdfn(32'h84)); end
    d_req15 = 1'b0;
    @(negedge clk);
    total++; if ({d_done15, busy15} !== 2'b0) begin bad++; $display("FAIL w15_after got=%0b exp=0", {d_done15, busy15}); end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    if_req0 = 1'b0; d_req0 = 1'b0; if_req15 = 1'b0; d_req15 = 1'b0;
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[4] = 32'h8C220004; ref_mem[4] = 32'h8C220004;
    exp_if_rd = '0; exp_d_rd = '0; last_own = 1'b0;
    test_reset();
    test_fetch();
    test_store();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    test_wait0();
    test_wait15();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
